// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns fetch PC, issues word requests, buffers {pc,instr}; grant->out_valid 2 cycles
// (1 with FETCH_QUEUE_BYPASS_EN); out_ready_i backpressure throttles issue via the count+outstanding credit.

// Generic flushable FIFO; registered storage, head read combinationally from the array.
module fetch_queue_fifo #(
  parameter int            W       = 32,
  parameter int            DEPTH   = 4,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dat_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i && !flush_i) mem_q[wr_q] <= dat_i;
    end
  end

  assign dat_o = mem_q[rd_q];
  assign cnt_o = cnt_q;
endmodule

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        out_valid_o,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  input  logic        out_ready_i
);
  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   FULL = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] dcnt, tcnt;
  logic [CW:0]   owed;
  logic [31:0]   tag_pc, head_pc, head_instr;
  logic          issue, rsp_any, rsp_drop, rsp_live, rsp_push, pop;

  // Tag FIFO holds only live requests; wrong-path ones are tracked by discard_q alone.
  assign owed      = {1'b0, tcnt} + {1'b0, discard_q};
  assign mem_req_o = rst_i && !redirect_i && (({1'b0, dcnt} + owed) < FULL);
  assign issue     = mem_req_o && mem_gnt_i;
  assign rsp_any   = mem_rvalid_i && (owed != '0);
  assign rsp_drop  = mem_rvalid_i && (discard_q != '0);
  assign rsp_live  = mem_rvalid_i && (discard_q == '0) && (tcnt != '0);
  assign pop       = !redirect_i && (dcnt != '0) && out_ready_i;
  assign mem_addr_o = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      discard_d  = CW'(owed - {{CW{1'b0}}, rsp_any});
    end else begin
      if (issue)    fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_drop) discard_d  = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  fetch_queue_fifo #(.W(32), .DEPTH(DEPTH), .RST_VAL(32'h0)) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (issue),
    .dat_i   (fetch_pc_q),
    .pop_i   (rsp_live),
    .dat_o   (tag_pc),
    .cnt_o   (tcnt)
  );

  fetch_queue_fifo #(.W(64), .DEPTH(DEPTH), .RST_VAL({RESET_PC, 32'h0})) u_dat_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (rsp_push),
    .dat_i   ({tag_pc, mem_rdata_i}),
    .pop_i   (pop),
    .dat_o   ({head_pc, head_instr}),
    .cnt_o   (dcnt)
  );

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  // A response consumed straight off the bus never occupies a FIFO slot.
  assign byp         = rsp_live && (dcnt == '0) && !redirect_i;
  assign rsp_push    = rsp_live && !redirect_i && !(byp && out_ready_i);
  assign out_valid_o = (dcnt != '0) || byp;
  assign out_pc_o    = byp ? tag_pc : head_pc;
  assign out_instr_o = byp ? mem_rdata_i : head_instr;
`else
  assign rsp_push    = rsp_live && !redirect_i;
  assign out_valid_o = (dcnt != '0);
  assign out_pc_o    = head_pc;
  assign out_instr_o = head_instr;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order memory model (fixed or random grant/latency).
module tb_fetch_queue;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, redirect, mem_req, mem_gnt, mem_rvalid, out_valid, out_ready;
  logic [31:0] redirect_pc, mem_addr, mem_rdata, out_instr, out_pc;

  int vectors = 0;
  int miscompares = 0;

  logic gnt_en = 1'b0;
  logic rnd_gnt = 1'b0;
  int   lat_min = 1;
  int   lat_max = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mreq_t;
  mreq_t       mq[$];
  logic [31:0] cyc = 32'd0;
  logic [31:0] last_due = 32'd0;
  logic [31:0] due_tmp;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .out_valid_o   (out_valid),
    .out_instr_o   (out_instr),
    .out_pc_o      (out_pc),
    .out_ready_i   (out_ready)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Memory: responses strictly in order, each no earlier than its own latency.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      cyc = cyc + 32'd1;
      mem_gnt = rnd_gnt ? ($urandom_range(0, 1) == 1) : gnt_en;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mdata(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
        due_tmp = cyc + 32'($urandom_range(lat_max, lat_min));
        if (due_tmp <= last_due) due_tmp = last_due + 32'd1;
        last_due = due_tmp;
        mq.push_back('{addr: mem_addr, due: due_tmp});
      end
    end
  end

  task automatic test_reset();
    gnt_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'(4 * c)) begin
        miscompares++; $display("FAIL stream_issue c=%0d: got req=%b addr=%h want req=1 addr=%h", c, mem_req, mem_addr, 32'(4 * c));
      end
      vectors++;
      if (c < FIRST) begin
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_early_valid c=%0d: got %b want 0", c, out_valid); end
      end else begin
        e = 32'(4 * (c - FIRST));
        if (out_valid !== 1'b1 || out_pc !== e || out_instr !== mdata(e)) begin
          miscompares++; $display("FAIL stream_out c=%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", c, out_valid, out_pc, out_instr, e, mdata(e));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full();
    int grants;
    logic [31:0] e;
    out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h1000;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL full_redirect_req: got %b want 0", mem_req); end
    @(posedge clk); #1;
    redirect = 1'b0;
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
        vectors++;
        if (mem_addr !== 32'h1000 + 32'(4 * grants)) begin
          miscompares++; $display("FAIL full_addr: got %h want %h", mem_addr, 32'h1000 + 32'(4 * grants));
        end
        grants++;
      end
      @(posedge clk); #1;
    end
    vectors++; if (grants != 4) begin miscompares++; $display("FAIL full_grants: got %0d want 4", grants); end
    @(negedge clk);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL full_req_low: got %b want 0", mem_req); end
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h1000) begin
      miscompares++; $display("FAIL full_head: got v=%b pc=%h want v=1 pc=00001000", out_valid, out_pc);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = 32'h1000 + 32'(4 * i);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== e || out_instr !== mdata(e)) begin
        miscompares++; $display("FAIL full_drain i=%0d: got v=%b pc=%h ins=%h want pc=%h", i, out_valid, out_pc, out_instr, e);
      end
      if (i == 0) begin
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL full_req_p0: got %b want 0", mem_req); end
      end
      if (i == 1) begin
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1010) begin
          miscompares++; $display("FAIL full_resume: got req=%b addr=%h want req=1 addr=00001010", mem_req, mem_addr);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_inflight();
    logic found;
    int pops;
    logic [31:0] e;
    @(posedge clk); #1;
    lat_min = 3; lat_max = 3;
    repeat (8) @(posedge clk);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(posedge clk); #2;
      if (mem_rvalid === 1'b1) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL inflight_no_rvalid: got none want rvalid within 12 cycles"); end
    redirect = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL inflight_redirect_req: got %b want 0", mem_req); end
    @(posedge clk); #1;
    redirect = 1'b0;
    pops = 0; e = 32'h100;
    for (int k = 0; k < 14 && pops < 2; k++) begin
      @(negedge clk);
      if (k == 0) begin
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
          miscompares++; $display("FAIL inflight_addr: got req=%b addr=%h want req=1 addr=00000100", mem_req, mem_addr);
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL inflight_flushed: got %b want 0", out_valid); end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (out_pc !== e || out_instr !== mdata(e)) begin
          miscompares++; $display("FAIL inflight_out: got pc=%h ins=%h want pc=%h ins=%h", out_pc, out_instr, e, mdata(e));
        end
        e = e + 32'd4; pops++;
      end
      @(posedge clk); #1;
    end
    vectors++; if (pops < 2) begin miscompares++; $display("FAIL inflight_timeout: got %0d pops want 2", pops); end
  endtask

  task automatic test_back_to_back();
    int pops;
    logic [31:0] e;
    @(posedge clk); #1;
    lat_min = 1; lat_max = 1;
    repeat (6) @(posedge clk);
    #1;
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL b2b_req0: got %b want 0", mem_req); end
    @(posedge clk); #1;
    redirect_pc = 32'h80;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL b2b_req1: got %b want 0", mem_req); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_flushed: got %b want 0", out_valid); end
    @(posedge clk); #1;
    redirect = 1'b0;
    pops = 0; e = 32'h80;
    for (int k = 0; k < 12 && pops < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
          miscompares++; $display("FAIL b2b_addr: got req=%b addr=%h want req=1 addr=00000080", mem_req, mem_addr);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (out_pc !== e || out_instr !== mdata(e)) begin
          miscompares++; $display("FAIL b2b_out: got pc=%h ins=%h want pc=%h", out_pc, out_instr, e);
        end
        e = e + 32'd4; pops++;
      end
      @(posedge clk); #1;
    end
    vectors++; if (pops < 3) begin miscompares++; $display("FAIL b2b_timeout: got %0d pops want 3", pops); end
  endtask

  task automatic test_wrap();
    int pops;
    logic [31:0] e;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    redirect = 1'b0;
    pops = 0; e = 32'hFFFF_FFFC;
    for (int k = 0; k < 12 && pops < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin
          miscompares++; $display("FAIL wrap_addr0: got req=%b addr=%h want req=1 addr=fffffffc", mem_req, mem_addr);
        end
      end
      if (k == 1) begin
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
          miscompares++; $display("FAIL wrap_addr1: got req=%b addr=%h want req=1 addr=00000000", mem_req, mem_addr);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (out_pc !== e || out_instr !== mdata(e)) begin
          miscompares++; $display("FAIL wrap_out: got pc=%h ins=%h want pc=%h", out_pc, out_instr, e);
        end
        e = e + 32'd4; pops++;
      end
      @(posedge clk); #1;
    end
    vectors++; if (pops < 3) begin miscompares++; $display("FAIL wrap_timeout: got %0d pops want 3", pops); end
  endtask

  task automatic test_random();
    int pops;
    logic [31:0] e;
    @(posedge clk); #1;
    rnd_gnt = 1'b1; lat_min = 1; lat_max = 3;
    redirect = 1'b1; redirect_pc = 32'h2000;
    @(posedge clk); #1;
    redirect = 1'b0;
    pops = 0; e = 32'h2000;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (out_pc !== e || out_instr !== mdata(e)) begin
          miscompares++; $display("FAIL random_seq k=%0d: got pc=%h ins=%h want pc=%h ins=%h", k, out_pc, out_instr, e, mdata(e));
          e = out_pc;
        end
        e = e + 32'd4; pops++;
      end
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    vectors++; if (pops < 100) begin miscompares++; $display("FAIL random_progress: got %0d pops want >=100", pops); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_inflight();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue sitting directly upstream of the single-cycle core: it owns the fetch PC, issues in-order word requests to instruction memory, and buffers returned instructions with their PCs in a small FIFO. The core pops one instruction per cycle and redirects fetch on taken branches and jumps. In-flight and buffered wrong-path instructions are flushed and discarded.

## Interface
- `DEPTH`, 4: FIFO entries and maximum outstanding requests; power of two, ≥2.
- `RESET_PC`, 32'h0: fetch PC after reset; word aligned.
- `clk` in 1: clock, rising edge.
- `rst` in 1: one clock; reset is synchronous and active-low.
- `redirect` in 1: core requests fetch from a new PC; flushes the queue.
- `redirect_pc` in 32: new fetch PC; bits [1:0] ignored, treated as 0.
- `mem_req` out 1: request valid to instruction memory.
- `mem_addr` out 32: word address of the request (current fetch PC).
- `mem_gnt` in 1: memory accepts request this cycle when `mem_req && mem_gnt`.
- `mem_rvalid` in 1: response valid; always accepted, no backpressure.
- `mem_rdata` in 32: instruction word for the oldest outstanding request.
- `out_valid` out 1: head entry valid.
- `out_instr` out 32: head instruction.
- `out_pc` out 32: PC of head instruction.
- `out_ready` in 1: core consumes head when `out_valid && out_ready`.

## Operation
- State: `fetch_pc`, FIFO of {pc, instr} (`count` 0..DEPTH), `outstanding` 0..DEPTH, `discard` 0..DEPTH, PC tag FIFO for outstanding requests.
- Reset (`rst`==0 at edge): `fetch_pc`=RESET_PC, count/outstanding/discard=0; outputs `mem_req`=0, `out_valid`=0, `out_instr`=0, `out_pc`=RESET_PC, `mem_addr`=RESET_PC.
- Issue: `mem_req` = !redirect && (count + outstanding) < DEPTH. On grant: tag `fetch_pc`, `outstanding`+1, `fetch_pc`+=4 (wraps mod 2^32).
- Response: if `discard`>0, drop word, `discard`−1, `outstanding`−1; else push {tag, `mem_rdata`}, `outstanding`−1. FIFO cannot overflow by credit rule.
- Pop: on `out_valid && out_ready`, head removed. Push and pop in the same cycle at any count are legal; count unchanged.
- Redirect (priority over push/pop/issue): FIFO cleared (count=0), `fetch_pc` = {redirect_pc[31:2],2'b00}, `discard` = outstanding − (1 if `mem_rvalid` this cycle and counted in `outstanding`) + existing outstanding discards accounted once; i.e. after the cycle, every response still owed is marked discard. A response arriving in the redirect cycle is dropped. No request issued in redirect cycle.
- Redirect while `discard`>0: discard set to total owed responses; never negative.
- `mem_rvalid` with `outstanding`==0 is a protocol error: ignored.

## Timing
- Earliest path: request granted cycle N, response N+1, `out_valid` N+2 (N+1 with bypass, see Configuration).
- Post-redirect: first new request issued cycle R+1; first new instruction valid no earlier than R+3.
- Sustained throughput one instruction/cycle when memory grants every cycle with 1-cycle latency and DEPTH≥2.
- All outputs except `mem_req` (and bypass path) driven from registers; `mem_req` combinational from `redirect` and counters.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when FIFO empty, `discard`==0, no redirect, and a response arrives, `out_valid`/`out_instr`/`out_pc` driven combinationally from the response; if popped that cycle it is not written. Otherwise written normally.
- Undefined: responses always enter the FIFO; outputs purely registered; one extra cycle latency.

## Test plan
- Reset with `rst`=0 two cycles, release, `mem_gnt`=1, 1-cycle memory -> addresses 0,4,8,... ; `out_pc` 0 valid at cycle 2 (cycle 1 with bypass), one per cycle after.
- `out_ready`=0 held -> exactly DEPTH=4 requests issued, `mem_req` falls, count=4; raise `out_ready` -> pops 0,4,8,C then fetch resumes at 0x10.
- Redirect to 0x103 with 2 outstanding and rvalid same cycle -> FIFO empties, 2 following responses dropped, next `mem_addr`=0x100, first `out_pc`=0x100.
- Back-to-back redirects (0x40 then 0x80 next cycle) -> no instruction from 0x40 path reaches output; first `out_pc`=0x80.
- `fetch_pc`=0xFFFFFFFC granted -> next `mem_addr`=0x0; `out_pc` sequence FFFFFFFC, 0.
- Random `mem_gnt`/latency 1-3 with simultaneous push/pop at count=DEPTH−1 -> output PCs strictly sequential, no loss/duplication.
